// File: rtl/iob_native_regbank_resp_pkg.sv
// iob_native_regbank_resp_pkg: shared handshake state encoding for the IOb native responder
package iob_native_regbank_resp_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;
endpackage

// File: rtl/iob_native_regbank_mem.sv
// iob_native_regbank_mem: N_REGS x DATA_W register array with byte-strobe write and registered read
module iob_native_regbank_mem #(
    parameter int IDX_W  = 2,
    parameter int DATA_W = 32,
    parameter int N_REGS = 4
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                en_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic [DATA_W-1:0]   rdata_o
);
    localparam int WSTRB_W = DATA_W / 8;
    logic [DATA_W-1:0] regs [N_REGS];
    logic [DATA_W-1:0] rd_word;
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < N_REGS; r++)
            if (idx_i == IDX_W'(r)) rd_word = regs[r];
    end
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int r = 0; r < N_REGS; r++) regs[r] <= '0;
            rdata_o <= '0;
        end else if (en_i) begin
            for (int r = 0; r < N_REGS; r++)
                for (int b = 0; b < WSTRB_W; b++)
                    if (idx_i == IDX_W'(r) && wstrb_i[b]) regs[r][8*b +: 8] <= wdata_i[8*b +: 8];
            if (~|wstrb_i) rdata_o <= rd_word;
        end
    end
endmodule

// File: rtl/iob_native_regbank_resp.sv
// iob_native_regbank_resp: IOb native responder with register bank; IOB_NATIVE_RESP_WAIT_EN adds wait states
module iob_native_regbank_resp
    import iob_native_regbank_resp_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 32,
    parameter int N_REGS      = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_i,
    input  logic                iob_valid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic                iob_ready_o,
    output logic                iob_rvalid_o
);
    localparam int IDX_W = ADDR_W - 2;
    logic accept;
    logic ready_q;
    logic rvalid_q;
    assign accept = cke_i & iob_valid_i & ready_q;
    assign iob_ready_o = ready_q;
    assign iob_rvalid_o = rvalid_q;
`ifdef IOB_NATIVE_RESP_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else if (cke_i) begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ready_q <= state_nxt == ACK;
        end
    end
    // a request withdrawn while waiting abandons the access
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (iob_valid_i) begin
                state_nxt = WAIT;
                cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
            end
            WAIT: begin
                state_nxt = !iob_valid_i ? IDLE : (cnt == '0) ? ACK : WAIT;
                cnt_nxt   = (iob_valid_i && cnt != '0) ? cnt - 1'b1 : '0;
            end
            default: state_nxt = IDLE;
        endcase
    end
`else
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) ready_q <= 1'b0;
        else if (cke_i) ready_q <= 1'b1;
    end
`endif
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) rvalid_q <= 1'b0;
        else if (cke_i) rvalid_q <= accept & ~|iob_wstrb_i;
    end
    iob_native_regbank_mem #(
        .IDX_W (IDX_W),
        .DATA_W(DATA_W),
        .N_REGS(N_REGS)
    ) u_mem (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .en_i   (accept),
        .idx_i  (iob_addr_i[ADDR_W-1:2]),
        .wdata_i(iob_wdata_i),
        .wstrb_i(iob_wstrb_i),
        .rdata_o(iob_rdata_o)
    );
endmodule

// File: tb/tb_iob_native_regbank_resp.sv
// tb_iob_native_regbank_resp: randomized self-checking bench against a byte-level register model
module tb_iob_native_regbank_resp;
    localparam int N = 3;
    logic        clk = 1'b0;
    logic        cke = 1'b1;
    logic        arst = 1'b1;
    logic        valid = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        rvalid;
    int checks = 0;
    int failures = 0;
    logic [7:0] mb [N][4];

    iob_native_regbank_resp #(
        .ADDR_W(4), .DATA_W(32), .N_REGS(N), .WAIT_CYCLES(2)
    ) dut (
        .clk_i(clk), .cke_i(cke), .arst_i(arst), .iob_valid_i(valid),
        .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_rdata_o(rdata), .iob_ready_o(ready), .iob_rvalid_o(rvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic m_clear();
        for (int i = 0; i < N; i++)
            for (int b = 0; b < 4; b++) mb[i][b] = 8'h00;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        int i = int'(a) / 4;
        if (i >= N) return 32'h0;
        return {mb[i][3], mb[i][2], mb[i][1], mb[i][0]};
    endfunction

    task automatic m_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int i = int'(a) / 4;
        if (i < N)
            for (int b = 0; b < 4; b++)
                if (s[b]) mb[i][b] = d[8*b +: 8];
    endtask

    // called at a negedge; returns at the negedge following the accept edge
    task automatic issue(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] e);
        int n = 0;
        valid = 1'b1; addr = a; wdata = d; wstrb = s; e = 32'h0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout addr=%h ready=%b required 1", a, ready);
            valid = 1'b0;
            @(negedge clk);
            return;
        end
        @(posedge clk);
        if (s == 4'h0) e = m_read(a);
        else m_write(a, d, s);
        @(negedge clk);
    endtask

    task automatic idle();
        valid = 1'b0; wstrb = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        m_clear();
        arst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        arst = 1'b0;
        @(negedge clk);
`ifdef IOB_NATIVE_RESP_WAIT_EN
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL post_reset_ready got=%b exp=0", ready); end
`else
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", ready); end
`endif
        issue(4'h4, 32'h0, 4'h0, e);
        checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL reset_read_rvalid got=%b exp=1", rvalid); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_read_rdata got=%h exp=0", rdata); end
        idle();
    endtask

    task automatic test_write_read();
        logic [31:0] e;
        issue(4'h8, 32'hDEADBEEF, 4'hF, e);
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL write_no_rvalid got=%b exp=0", rvalid); end
        issue(4'h8, 32'h0, 4'h0, e);
        checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL raw_rvalid got=%b exp=1", rvalid); end
        checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL raw_rdata got=%h exp=deadbeef", rdata); end
        idle();
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_width got=%b exp=0", rvalid); end
        checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rdata_hold got=%h exp=deadbeef", rdata); end
    endtask

    task automatic test_partial_write();
        logic [31:0] e;
        issue(4'h8, 32'h000000AA, 4'h1, e);
        issue(4'h8, 32'h0, 4'h0, e);
        checks++; if (rdata !== 32'hDEADBEAA) begin failures++; $display("FAIL partial_rdata got=%h exp=deadbeaa", rdata); end
        checks++; if (rdata !== e) begin failures++; $display("FAIL partial_model got=%h exp=%h", rdata, e); end
        idle();
    endtask

    task automatic test_out_of_range();
        logic [31:0] e;
        issue(4'hC, 32'h55555555, 4'hF, e);
        issue(4'hC, 32'h0, 4'h0, e);
        checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL oor_rvalid got=%b exp=1", rvalid); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL oor_rdata got=%h exp=0", rdata); end
        idle();
    endtask

    task automatic test_cke();
        logic [31:0] e;
        cke = 1'b0; valid = 1'b1; addr = 4'h8; wstrb = 4'h0;
        repeat (4) begin
            @(negedge clk);
            checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL cke_read_rvalid got=%b exp=0", rvalid); end
        end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL cke_rdata_hold got=%h exp=0", rdata); end
        addr = 4'h0; wdata = 32'h12345678; wstrb = 4'hF;
        repeat (4) @(negedge clk);
        valid = 1'b0; wstrb = 4'h0; cke = 1'b1;
        @(negedge clk);
        issue(4'h0, 32'h0, 4'h0, e);
        checks++; if (rdata !== e) begin failures++; $display("FAIL cke_write_blocked got=%h exp=%h", rdata, e); end
        idle();
    endtask

    task automatic test_wait();
`ifdef IOB_NATIVE_RESP_WAIT_EN
        logic [31:0] e;
        idle();
        valid = 1'b1; addr = 4'h4; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (ready !== (k == 3)) begin failures++; $display("FAIL wait_ready cycle=%0d got=%b exp=%b", k, ready, k == 3); end
        end
        @(posedge clk);
        m_write(4'h4, 32'hA5A5A5A5, 4'hF);
        @(negedge clk);
        valid = 1'b0; wstrb = 4'h0;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL wait_ready_width got=%b exp=0", ready); end
        idle();
        valid = 1'b1; addr = 4'h0; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        @(negedge clk);
        valid = 1'b0; wstrb = 4'h0;
        repeat (6) begin
            @(negedge clk);
            checks++; if (ready !== 1'b0) begin failures++; $display("FAIL drop_ready got=%b exp=0", ready); end
        end
        issue(4'h0, 32'h0, 4'h0, e);
        checks++; if (rdata !== e) begin failures++; $display("FAIL drop_no_write got=%h exp=%h", rdata, e); end
        issue(4'h4, 32'h0, 4'h0, e);
        checks++; if (rdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL wait_write got=%h exp=a5a5a5a5", rdata); end
        idle();
`endif
    endtask

    task automatic test_random();
        logic [31:0] e, d;
        logic [3:0] a, s;
        for (int i = 0; i < 80; i++) begin
            a = 4'($urandom_range(0, 15));
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            d = $urandom;
            issue(a, d, s, e);
            if (s == 4'h0) begin
                checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL rand_rvalid i=%0d got=%b exp=1", i, rvalid); end
                checks++; if (rdata !== e) begin failures++; $display("FAIL rand_rdata i=%0d addr=%h got=%h exp=%h", i, a, rdata, e); end
            end else begin
                checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rand_wr_rvalid i=%0d got=%b exp=0", i, rvalid); end
            end
            if ($urandom_range(0, 3) == 0) begin
                idle();
                checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rand_idle_rvalid i=%0d got=%b exp=0", i, rvalid); end
            end
        end
        for (int r = 0; r < 4; r++) begin
            issue(4'(r * 4), 32'h0, 4'h0, e);
            checks++; if (rdata !== e) begin failures++; $display("FAIL sweep_rdata reg=%0d got=%h exp=%h", r, rdata, e); end
        end
        idle();
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] e;
        int n = 0;
        issue(4'h0, $urandom | 32'h1, 4'hF, e);
        idle();
        valid = 1'b1; addr = 4'h0; wstrb = 4'h0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL midrst_accept got=%b exp=1", ready); end
        @(posedge clk);
        #1 arst = 1'b1;
        valid = 1'b0;
        m_clear();
        @(negedge clk);
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL midrst_rvalid got=%b exp=0", rvalid); end
        arst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL midrst_no_rvalid got=%b exp=0", rvalid); end
        end
        for (int r = 0; r < N; r++) begin
            issue(4'(r * 4), 32'h0, 4'h0, e);
            checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL midrst_reg reg=%0d got=%h exp=0", r, rdata); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_out_of_range();
        test_cke();
        test_wait();
        test_random();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
